// File: rtl/m_dm.sv
// m_dm -- data memory for the M stage of the five-stage pipeline.
//
// Performs byte/half/word stores on the rising clock edge and returns
// sign- or zero-extended load data combinationally. Every committed store
// is logged to the simulation console.
//
// Ports:
//   clk        in   1   system clock, rising edge
//   reset      in   1   asynchronous, active-high; clears the whole array
//   pc         in  32   PC of the instruction in M (write log only)
//   addr       in  32   byte address (ALU result)
//   wdata      in  32   store data (forwarded rt)
//   st_op      in   2   0 none, 1 SW, 2 SH, 3 SB
//   ld_op      in   3   0 none, 1 LW, 2 LH, 3 LHU, 4 LB, 5 LBU, 6/7 none
//   rdata      out 32   extended load result
//   align_err  out  1   access misaligned or out of range
module m_dm #(
   parameter int DEPTH = 3072,
   parameter int AW    = 12
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] pc,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   input  logic [1:0]  st_op,
   input  logic [2:0]  ld_op,
   output logic [31:0] rdata,
   output logic        align_err
);

   localparam logic [31:0] BYTES = 32'(4 * DEPTH);

   localparam logic [1:0] ST_NONE = 2'd0;
   localparam logic [1:0] ST_SW   = 2'd1;
   localparam logic [1:0] ST_SH   = 2'd2;
   localparam logic [1:0] ST_SB   = 2'd3;

   localparam logic [2:0] LD_LW  = 3'd1;
   localparam logic [2:0] LD_LH  = 3'd2;
   localparam logic [2:0] LD_LHU = 3'd3;
   localparam logic [2:0] LD_LB  = 3'd4;
   localparam logic [2:0] LD_LBU = 3'd5;

   logic [31:0]   mem_q [DEPTH];

   logic [AW-1:0] idx_s;
   logic [1:0]    lane_s;
   logic          ld_valid_s;
   logic          in_range_s;
   logic          active_s;
   logic          word_acc_s;
   logic          half_acc_s;
   logic [3:0]    be_s;
   logic [31:0]   wrep_s;
   logic [31:0]   rd_word_s;
   logic [31:0]   merged_d;
   logic          we_s;
   logic [15:0]   half_s;
   logic [7:0]    byte_s;

   assign idx_s  = addr[AW+1:2];
   assign lane_s = addr[1:0];

   // Access classification and misalignment/range detection.
   always_comb begin
      ld_valid_s = (ld_op >= LD_LW) && (ld_op <= LD_LBU);
      in_range_s = (addr < BYTES);
      active_s   = (st_op != ST_NONE) || ld_valid_s;
      word_acc_s = (st_op == ST_SW) || (ld_op == LD_LW);
      half_acc_s = (st_op == ST_SH) || (ld_op == LD_LH) || (ld_op == LD_LHU);
      align_err  = (word_acc_s && (lane_s != 2'b00)) ||
                   (half_acc_s && addr[0]) ||
                   (active_s && !in_range_s);
   end

   // Byte enables and replicated store data for the requested store width.
   always_comb begin
      be_s   = 4'b0000;
      wrep_s = wdata;
      case (st_op)
         ST_SW: begin
            be_s   = 4'b1111;
            wrep_s = wdata;
         end
         ST_SH: begin
            be_s   = addr[1] ? 4'b1100 : 4'b0011;
            wrep_s = {2{wdata[15:0]}};
         end
         ST_SB: begin
            be_s   = 4'b0001 << lane_s;
            wrep_s = {4{wdata[7:0]}};
         end
         default: begin
            be_s   = 4'b0000;
            wrep_s = wdata;
         end
      endcase
   end

   // Current word (guarded so an out-of-range index never reads the array)
   // and the word as it will look after the byte merge.
   always_comb begin
      rd_word_s = 32'h0000_0000;
      if (in_range_s) begin
         rd_word_s = mem_q[idx_s];
      end else begin
         rd_word_s = 32'h0000_0000;
      end
      for (int i = 0; i < 4; i++) begin
         merged_d[8*i +: 8] = be_s[i] ? wrep_s[8*i +: 8] : rd_word_s[8*i +: 8];
      end
   end

   assign we_s = (st_op != ST_NONE) && !align_err;

   // Memory array: async clear on reset, committed store on the clock edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= 32'h0000_0000;
         end
      end else if (we_s) begin
         mem_q[idx_s] <= merged_d;
`ifndef SYNTHESIS
         $display("%d@%h: *%h <= %h", $time, pc, {addr[31:2], 2'b00}, merged_d);
`endif
      end
   end

   // Load extraction; a faulting or absent load returns zero. A load issued
   // alongside a store sees the pre-store word since the array only updates
   // at the edge.
   always_comb begin
      half_s = addr[1] ? rd_word_s[31:16] : rd_word_s[15:0];
      byte_s = rd_word_s[{lane_s, 3'b000} +: 8];
      rdata  = 32'h0000_0000;
      if (align_err) begin
         rdata = 32'h0000_0000;
      end else begin
         case (ld_op)
            LD_LW:   rdata = rd_word_s;
            LD_LH:   rdata = {{16{half_s[15]}}, half_s};
            LD_LHU:  rdata = {16'h0000, half_s};
            LD_LB:   rdata = {{24{byte_s[7]}}, byte_s};
            LD_LBU:  rdata = {24'h00_0000, byte_s};
            default: rdata = 32'h0000_0000;
         endcase
      end
   end

endmodule
